nios_input_pio_db: RTL and testbench

Parametrised Avalon-MM input PIO for the Nios II platform. Successor to the fixed 2-bit switch port: adds WIDTH channels, input synchronisation, per-channel debounce, edge capture and a maskable level interrupt. Sits between board switches/buttons and the CPU data-master interconnect; its irq goes to the Nios IRQ receiver.

---
 rtl/nios_pio_pkg.sv | 16 +
 rtl/pio_debounce_ch.sv | 60 ++++++
 rtl/nios_input_pio_db.sv | 88 ++++++++
 tb/tb_nios_input_pio_db.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// Shared register addresses, address type and debounce-counter sizing for the input PIO.
package nios_pio_pkg;

   typedef logic [1:0] pio_addr_t;

   localparam pio_addr_t ADDR_DATA    = 2'd0;
   localparam pio_addr_t ADDR_RSVD    = 2'd1;
   localparam pio_addr_t ADDR_IRQMASK = 2'd2;
   localparam pio_addr_t ADDR_EDGE    = 2'd3;

   // Width able to hold 0..cycles; never below 1 bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: multi-flop synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module pio_debounce_ch
   import nios_pio_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_in,
   output logic o_stable
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
   logic                   r_stable;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      end
   end

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign o_stable = r_stable;

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_stable <= 1'b0;
         end else begin
            r_stable <= w_sync;
         end
      end
   end else begin : g_debounce
      localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;

      // Counter stops at LP_LAST by construction, so it can never wrap.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
         end else if (w_sync == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt >= LP_LAST) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/nios_input_pio_db.sv
// Avalon-MM input PIO: debounced inputs, edge capture (W1C) and a maskable level irq.
// Define PIO_EDGE_ANY_EN to capture falling as well as rising edges.
module nios_input_pio_db
   import nios_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  pio_addr_t        address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [31:0] LP_MASK =
      (WIDTH >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << WIDTH) - 64'd1);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] r_prev;
   logic [31:0]      w_stable32;
   logic [31:0]      w_edge32;
   logic [31:0]      w_clr;
   logic             w_wr;
   logic [31:0]      r_irqmask;
   logic [31:0]      r_edge;
   logic [31:0]      r_readdata;
   logic             r_irq;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      pio_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .i_in     (in_port[g]),
         .o_stable (w_stable[g])
      );
   end

`ifdef PIO_EDGE_ANY_EN
   assign w_edge = w_stable ^ r_prev;
`else
   assign w_edge = w_stable & ~r_prev;
`endif

   assign w_stable32 = 32'(w_stable);
   assign w_edge32   = 32'(w_edge);
   assign w_wr       = chipselect & ~write_n;
   assign w_clr      = (w_wr && address == ADDR_EDGE) ? (writedata & LP_MASK) : 32'h0;

   // Mask and capture registers are kept 32 bits wide; bits above WIDTH stay zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev     <= '0;
         r_irqmask  <= '0;
         r_edge     <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_prev <= w_stable;
         if (w_wr && address == ADDR_IRQMASK) begin
            r_irqmask <= writedata & LP_MASK;
         end
         // Set wins over a simultaneous clear of the same bit.
         r_edge <= (r_edge & ~w_clr) | w_edge32;
         r_irq  <= |(r_edge & r_irqmask);
         case (address)
            ADDR_DATA:    r_readdata <= w_stable32;
            ADDR_RSVD:    r_readdata <= 32'h0;
            ADDR_IRQMASK: r_readdata <= r_irqmask;
            ADDR_EDGE:    r_readdata <= r_edge;
            default:      r_readdata <= 32'h0;
         endcase
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_nios_input_pio_db.sv
// Directed self-checking bench for nios_input_pio_db (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_nios_input_pio_db;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd;
   int          cnt;
   logic        seen;
   logic [31:0] exp_fall;
   logic        exp_irq_all;

   nios_input_pio_db #(
      .WIDTH           (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   initial begin
`ifdef PIO_EDGE_ANY_EN
      exp_fall    = 32'h2;
      exp_irq_all = 1'b1;
`else
      exp_fall    = 32'h0;
      exp_irq_all = 1'b0;
`endif
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 4'hF;
      repeat (4) tick();
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);

      // Release: stable after 2 sync + 4 debounce edges, visible one edge later.
      reset_n = 1'b1;
      repeat (6) tick();
      check("data_before_accept", readdata, 32'h0);
      tick();
      check("data_after_accept", readdata, 32'hF);
      tick();
      check("no_irq_masked", {31'h0, irq}, 32'h0);
      do_read(2'd3, rd);
      check("powerup_edges", rd, 32'hF);

      // Bring to a known pattern and clear captures.
      in_port = 4'h2;
      repeat (10) tick();
      do_write(2'd3, 32'hF);
      do_read(2'd3, rd);
      check("edge_cleared", rd, 32'h0);

      // 3-cycle pulses must be rejected.
      for (int i = 0; i < 5; i++) begin
         in_port[0] = 1'b1;
         repeat (3) tick();
         in_port[0] = 1'b0;
         repeat (3) tick();
      end
      repeat (4) tick();
      do_read(2'd0, rd);
      check("bounce_data", rd, 32'h2);
      do_read(2'd3, rd);
      check("bounce_edge", rd, 32'h0);

      // Unmask bit0, then an accepted rise: capture at edge 7, irq and readback at edge 8.
      do_write(2'd2, 32'h1);
      tick();
      check("irq_idle_masked", {31'h0, irq}, 32'h0);
      address    = 2'd3;
      in_port[0] = 1'b1;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 20) begin
         tick();
         cnt++;
         if (irq) seen = 1'b1;
      end
      check("irq_latency", cnt, 8);
      check("edge_bit0_with_irq", readdata, 32'h1);
      do_read(2'd0, rd);
      check("data_bit0_high", rd, 32'h3);

      do_write(2'd3, 32'h0);
      do_read(2'd3, rd);
      check("w0_no_effect", rd, 32'h1);
      check("w0_irq_held", {31'h0, irq}, 32'h1);
      do_write(2'd3, 32'h1);
      check("irq_same_edge_as_clear", {31'h0, irq}, 32'h1);
      tick();
      check("irq_after_clear", {31'h0, irq}, 32'h0);

      // Set wins: W1C of bit2 lands on the same edge the capture sets.
      in_port[2] = 1'b1;
      repeat (6) tick();
      do_write(2'd3, 32'h4);
      do_read(2'd3, rd);
      check("set_wins", rd, 32'h4);
      do_write(2'd3, 32'h4);
      do_read(2'd3, rd);
      check("w1c_bit2", rd, 32'h0);

      // Falling edge on bit1.
      in_port[1] = 1'b0;
      repeat (10) tick();
      do_read(2'd0, rd);
      check("fall_data", rd, 32'h5);
      do_read(2'd3, rd);
      check("fall_edge", rd, exp_fall);

      // Map and width.
      do_read(2'd1, rd);
      check("rsvd_zero", rd, 32'h0);
      do_write(2'd2, 32'hFFFF_FFFF);
      do_read(2'd2, rd);
      check("irqmask_width", rd, 32'h0000_000F);
      check("irq_all_mask", {31'h0, irq}, {31'h0, exp_irq_all});
      do_write(2'd0, 32'h0);
      do_read(2'd0, rd);
      check("data_ro", rd, 32'h5);
      address = 2'd1;
      #2;
      check("latency_old_value", readdata, 32'h5);
      tick();
      check("latency_new_value", readdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
